sram_array_ctrl: RTL and testbench

Sequencer for the bit-cell SRAM array built from `wordCell` rows: accepts single-word read/write requests on a valid/ready port and drives the array's shared `rw`, `word` bus and one-hot `wordLine` vector with a fixed, glitch-free phase order (setup → wordline pulse → recover). On reads it captures the array's chained bitline output during the wordline pulse. It sits between the CPU/testbench-side request logic and the row stack of `wordCell` instances.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/wl_decoder.sv | 22 ++
 rtl/sram_array_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_array_ctrl.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM array sequencer and its wordline decoder.
package sram_pkg;

    // Controller phases: idle, bus setup, wordline pulse, bus recovery.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PULSE   = 2'd2,
        RECOVER = 2'd3
    } state_e;

    // Word width of a wordCell row.
    localparam int DEFAULT_DATA_W = 8;

    // Returns 1 when the given row is the one selected by addr.
    function automatic logic onehot_bit(input int addr, input int row);
        return addr == row;
    endfunction

endpackage

// File: rtl/wl_decoder.sv
// Row address to one-hot wordline decoder with enable; combinational, registered by the caller.
module wl_decoder
    import sram_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   en_i,
    output logic [(2**ADDR_W)-1:0] onehot_o
);

    localparam int ROWS = 2**ADDR_W;

    // Drive exactly one row high when enabled, none otherwise.
    always_comb begin
        onehot_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            onehot_o[r] = en_i && onehot_bit(int'(addr_i), r);
        end
    end

endmodule

// File: rtl/sram_array_ctrl.sv
// Sequencer for the wordCell SRAM array: takes one request at a time and walks the
// shared array bus through setup, a wordline pulse and a recovery cycle so the
// wordline is never high while rw/word change. Reads capture the chained bitlines.
module sram_array_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int WL_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   arr_rw,
    output logic [DATA_W-1:0]      arr_word,
    output logic [(2**ADDR_W)-1:0] arr_wordline,
    output logic [DATA_W-1:0]      arr_bl_carry,
    input  logic [DATA_W-1:0]      arr_bl_out
);

    localparam int ROWS  = 2**ADDR_W;
    localparam int CNT_W = (WL_CYCLES > 1) ? $clog2(WL_CYCLES) : 1;

    // A zero-length pulse would never open the row, and the rows are 8 bits wide.
    generate
        if (WL_CYCLES < 1) begin : g_bad_wl_cycles
            $error("sram_array_ctrl: WL_CYCLES must be at least 1");
        end
        if (DATA_W != DEFAULT_DATA_W) begin : g_bad_data_w
            $error("sram_array_ctrl: DATA_W must match the wordCell width");
        end
    endgenerate

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ROWS-1:0]   wl_q, wl_d;

    // The wordline is decoded from the next state so that it can be registered
    // and leave the block glitch-free straight from a flop.
    wl_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wl_decoder (
        .addr_i   (addr_q),
        .en_i     (state_d == PULSE),
        .onehot_o (wl_d)
    );

    // Next-state logic: latch the request, sequence the phases and capture read data.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    rw_d    = req_we;
                    word_d  = req_we ? req_wdata : '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(WL_CYCLES - 1);
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    if (!we_q) begin
                        rdata_d = arr_bl_out;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                rw_d    = 1'b0;
                word_d  = '0;
                state_d = IDLE;
            end
            default: begin
                rw_d    = 1'b0;
                word_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and array-bus registers; reset drops the wordline immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            word_q  <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            word_q  <= word_d;
            wl_q    <= wl_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RECOVER);
    assign resp_rdata   = rdata_q;
    assign arr_rw       = rw_q;
    assign arr_word     = word_q;
    assign arr_wordline = wl_q;
    assign arr_bl_carry = '0;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl: one instance with a 1-cycle pulse and one
// with a 3-cycle pulse, each driving a small behavioural model of a 4-row wordCell stack.
module tb_sram_array_ctrl;

    logic       clk;
    logic       rst;

    logic       reqValid, reqWe;
    logic [1:0] reqAddr;
    logic [7:0] reqWdata;
    logic       reqReady, respValid, arrRw;
    logic [7:0] respRdata, arrWord, blCarry, blOut;
    logic [3:0] arrWl;

    logic       reqValid3, reqWe3;
    logic [1:0] reqAddr3;
    logic [7:0] reqWdata3;
    logic       reqReady3, respValid3, arrRw3;
    logic [7:0] respRdata3, arrWord3, blCarry3, blOut3;
    logic [3:0] arrWl3;

    int errors;
    int checks;

    logic [7:0] mem1 [4];
    logic [7:0] mem3 [4];
    logic [7:0] expMem [4];
    logic [7:0] expMem3 [4];
    logic [7:0] expQ [$];
    logic [7:0] lastRd;

    logic       hRw [3];
    logic [7:0] hWord [3];
    logic [3:0] hWl [3];
    int         hCnt;

    sram_array_ctrl #(.ADDR_W(2), .DATA_W(8), .WL_CYCLES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (reqValid),
        .req_ready    (reqReady),
        .req_we       (reqWe),
        .req_addr     (reqAddr),
        .req_wdata    (reqWdata),
        .resp_valid   (respValid),
        .resp_rdata   (respRdata),
        .arr_rw       (arrRw),
        .arr_word     (arrWord),
        .arr_wordline (arrWl),
        .arr_bl_carry (blCarry),
        .arr_bl_out   (blOut)
    );

    sram_array_ctrl #(.ADDR_W(2), .DATA_W(8), .WL_CYCLES(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (reqValid3),
        .req_ready    (reqReady3),
        .req_we       (reqWe3),
        .req_addr     (reqAddr3),
        .req_wdata    (reqWdata3),
        .resp_valid   (respValid3),
        .resp_rdata   (respRdata3),
        .arr_rw       (arrRw3),
        .arr_word     (arrWord3),
        .arr_wordline (arrWl3),
        .arr_bl_carry (blCarry3),
        .arr_bl_out   (blOut3)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Row stacks: a selected row stores the word while rw is high, and drives its
    // contents onto the chained bitlines while rw is low.
    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (arrRw && arrWl[r]) mem1[r] <= arrWord;
            if (arrRw3 && arrWl3[r]) mem3[r] <= arrWord3;
        end
    end

    always_comb begin
        blOut  = blCarry;
        blOut3 = blCarry3;
        for (int r = 0; r < 4; r++) begin
            if (!arrRw && arrWl[r]) blOut = blOut | mem1[r];
            if (!arrRw3 && arrWl3[r]) blOut3 = blOut3 | mem3[r];
        end
    end

    // Phase watcher: any cycle with a raised wordline must see rw/word unchanged from
    // the cycle before to the cycle after, and at most one wordline may be high.
    always @(negedge clk) begin
        if (rst) begin
            hCnt = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                hRw[k]   = hRw[k+1];
                hWord[k] = hWord[k+1];
                hWl[k]   = hWl[k+1];
            end
            hRw[2]   = arrRw;
            hWord[2] = arrWord;
            hWl[2]   = arrWl;
            hCnt++;
            if (hCnt >= 3 && hWl[1] != 4'b0000) begin
                checks++;
                if (hRw[0] !== hRw[1] || hRw[1] !== hRw[2] ||
                    hWord[0] !== hWord[1] || hWord[1] !== hWord[2]) begin
                    errors++;
                    $display("[TB] FAIL phase_hold: rw %b/%b/%b word %h/%h/%h around wordline %b, required all equal",
                             hRw[0], hRw[1], hRw[2], hWord[0], hWord[1], hWord[2], hWl[1]);
                end
            end
            if (hWl[2] != 4'b0000) begin
                checks++;
                if ($countones(hWl[2]) != 1) begin
                    errors++;
                    $display("[TB] FAIL wordline_onehot: got %b, required exactly one bit", hWl[2]);
                end
            end
        end
    end

    // One request on the WL_CYCLES=1 instance, checked for latency, wordline and data.
    task automatic doOp(input logic we, input logic [1:0] addr, input logic [7:0] data, input string tag);
        int         lat;
        int         waitN;
        logic [7:0] expRd;
        logic [3:0] expWl;
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = data;
        waitN    = 0;
        while (!reqReady && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        checks++;
        if (!reqReady) begin
            errors++;
            $display("[TB] FAIL %s_accept: req_ready=%b, required 1 within 20 cycles", tag, reqReady);
            reqValid = 1'b0;
            return;
        end
        if (we) expMem[addr] = data;
        else    expQ.push_back(expMem[addr]);
        @(posedge clk);
        #1 reqValid = 1'b0;
        expWl = 4'b0001 << addr;
        lat   = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            checks++;
            if (arrWl !== ((lat == 2) ? expWl : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL %s_wordline: cycle %0d got %b, required %b",
                         tag, lat, arrWl, (lat == 2) ? expWl : 4'b0000);
            end
            if (respValid) break;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL %s_latency: resp_valid at cycle %0d, required 3", tag, lat);
        end
        if (respValid) begin
            if (!we) begin
                expRd = expQ.pop_front();
                lastRd = expRd;
            end else begin
                expRd = lastRd;
            end
            checks++;
            if (respRdata !== expRd) begin
                errors++;
                $display("[TB] FAIL %s_rdata: got %h, required %h", tag, respRdata, expRd);
            end
        end
    endtask

    // One request on the WL_CYCLES=3 instance, checked for pulse width and timing.
    task automatic op3(input logic we, input logic [1:0] addr, input logic [7:0] data, input string tag);
        int         n;
        int         waitN;
        int         wlCnt;
        int         wlFirst;
        int         respAt;
        int         readyAt;
        logic [7:0] rd;
        @(negedge clk);
        reqValid3 = 1'b1;
        reqWe3    = we;
        reqAddr3  = addr;
        reqWdata3 = data;
        waitN     = 0;
        while (!reqReady3 && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        checks++;
        if (!reqReady3) begin
            errors++;
            $display("[TB] FAIL %s_accept: req_ready=%b, required 1 within 20 cycles", tag, reqReady3);
            reqValid3 = 1'b0;
            return;
        end
        if (we) expMem3[addr] = data;
        @(posedge clk);
        #1 reqValid3 = 1'b0;
        n = 0; wlCnt = 0; wlFirst = 0; respAt = 0; readyAt = 0; rd = '0;
        while (n < 15 && readyAt == 0) begin
            @(negedge clk);
            n++;
            if (arrWl3 != 4'b0000) begin
                wlCnt++;
                if (wlFirst == 0) wlFirst = n;
                checks++;
                if (arrWl3 !== (4'b0001 << addr)) begin
                    errors++;
                    $display("[TB] FAIL %s_wl_value: cycle %0d got %b, required %b", tag, n, arrWl3, 4'b0001 << addr);
                end
            end
            if (respValid3 && respAt == 0) begin
                respAt = n;
                rd     = respRdata3;
            end
            if (reqReady3) readyAt = n;
        end
        checks++;
        if (wlCnt != 3 || wlFirst != 2) begin
            errors++;
            $display("[TB] FAIL %s_pulse: %0d wordline cycles from cycle %0d, required 3 from cycle 2", tag, wlCnt, wlFirst);
        end
        checks++;
        if (respAt != 5) begin
            errors++;
            $display("[TB] FAIL %s_resp_cycle: got %0d, required 5", tag, respAt);
        end
        checks++;
        if (readyAt != 6) begin
            errors++;
            $display("[TB] FAIL %s_ready_cycle: got %0d, required 6", tag, readyAt);
        end
        if (!we) begin
            checks++;
            if (rd !== expMem3[addr]) begin
                errors++;
                $display("[TB] FAIL %s_rdata: got %h, required %h", tag, rd, expMem3[addr]);
            end
        end
    endtask

    // Values held while reset is asserted and just after it is released.
    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({reqReady, respValid, respRdata, arrRw, arrWord, arrWl, blCarry} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ready=%b resp=%b rdata=%h rw=%b word=%h wl=%b carry=%h, required 1 0 00 0 00 0000 00",
                     reqReady, respValid, respRdata, arrRw, arrWord, arrWl, blCarry);
        end
        checks++;
        if (reqReady3 !== 1'b1 || arrWl3 !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_dut3: ready=%b wl=%b, required 1 0000", reqReady3, arrWl3);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: ready=%b resp=%b, required 1 0", reqReady, respValid);
        end
    endtask

    // Reset asserted during a write pulse must drop the wordline with no clock edge.
    task automatic test_reset_mid_pulse;
        bit sawResp;
        @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 2'd2; reqWdata = 8'hE1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (arrWl !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midreset_pulse: wordline %b, required 0100", arrWl);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (arrWl !== 4'b0000 || respValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: wordline %b resp=%b, required 0000 0", arrWl, respValid);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        sawResp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (respValid) sawResp = 1'b1;
        end
        checks++;
        if (sawResp || reqReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_after: resp seen=%b ready=%b, required 0 1", sawResp, reqReady);
        end
    endtask

    task automatic test_round_trip;
        doOp(1'b1, 2'd1, 8'h55, "rt_write");
        doOp(1'b0, 2'd1, 8'h00, "rt_read");
    endtask

    task automatic test_isolation;
        doOp(1'b1, 2'd0, 8'h38, "iso_w0");
        doOp(1'b1, 2'd3, 8'hC7, "iso_w3");
        doOp(1'b1, 2'd2, 8'h9A, "iso_w2");
        doOp(1'b0, 2'd0, 8'h00, "iso_r0");
        doOp(1'b0, 2'd3, 8'h00, "iso_r3");
        doOp(1'b0, 2'd2, 8'h00, "iso_r2");
    endtask

    task automatic test_pulse_width;
        op3(1'b1, 2'd2, 8'hA5, "pw_write");
        op3(1'b0, 2'd2, 8'h00, "pw_read");
    endtask

    // Valid held high with a moving address while busy: only the IDLE-cycle address runs.
    task automatic test_backpressure;
        int         wlBad;
        int         resps;
        int         extra;
        logic [7:0] rd;
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_idle: req_ready=%b, required 1", reqReady);
        end
        reqValid = 1'b1; reqWe = 1'b0;
        wlBad = 0; resps = 0; extra = 0; rd = '0;
        for (int i = 0; i < 4; i++) begin
            reqAddr = 2'(i);
            @(negedge clk);
            if (arrWl != 4'b0000 && arrWl != 4'b0001) wlBad++;
            if (respValid) begin
                resps++;
                rd = respRdata;
            end
        end
        reqValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (arrWl != 4'b0000 || respValid) extra++;
        end
        checks++;
        if (wlBad != 0 || extra != 0) begin
            errors++;
            $display("[TB] FAIL bp_wordline: %0d wrong-row cycles, %0d later active cycles, required 0 0", wlBad, extra);
        end
        checks++;
        if (resps != 1 || rd !== expMem[0]) begin
            errors++;
            $display("[TB] FAIL bp_response: %0d responses data %h, required 1 data %h", resps, rd, expMem[0]);
        end
        lastRd = expMem[0];
    endtask

    // Valid held high across a sequence of ops: one accept per IDLE cycle, scoreboarded.
    task automatic test_back_to_back;
        logic       opWe [3];
        logic [1:0] opAddr [3];
        logic [7:0] opData [3];
        logic [7:0] lastExp;
        logic [7:0] expRd;
        int         acc;
        int         resps;
        int         cyc;
        int         lastAcc;
        opWe   = '{1'b0, 1'b1, 1'b0};
        opAddr = '{2'd3, 2'd1, 2'd1};
        opData = '{8'h00, 8'hB4, 8'h00};
        lastExp = lastRd;
        acc = 0; resps = 0; cyc = 0; lastAcc = -1;
        expQ.delete();
        @(negedge clk);
        while ((acc < 3 || resps < 3) && cyc < 40) begin
            if (acc < 3) begin
                reqValid = 1'b1; reqWe = opWe[acc]; reqAddr = opAddr[acc]; reqWdata = opData[acc];
            end else begin
                reqValid = 1'b0;
            end
            if (reqValid && reqReady) begin
                if (opWe[acc]) begin
                    expMem[opAddr[acc]] = opData[acc];
                end else begin
                    lastExp = expMem[opAddr[acc]];
                end
                expQ.push_back(lastExp);
                if (lastAcc >= 0) begin
                    checks++;
                    if (cyc - lastAcc != 4) begin
                        errors++;
                        $display("[TB] FAIL b2b_gap: accept spacing %0d cycles, required 4", cyc - lastAcc);
                    end
                end
                lastAcc = cyc;
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (respValid && expQ.size() > 0) begin
                expRd = expQ.pop_front();
                resps++;
                checks++;
                if (respRdata !== expRd) begin
                    errors++;
                    $display("[TB] FAIL b2b_rdata: response %0d got %h, required %h", resps, respRdata, expRd);
                end
            end
        end
        reqValid = 1'b0;
        lastRd = lastExp;
        checks++;
        if (acc != 3 || resps != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: %0d accepts %0d responses, required 3 3", acc, resps);
        end
    endtask

    // Test sequence and summary.
    initial begin
        clk = 1'b0; rst = 1'b1;
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
        reqValid3 = 1'b0; reqWe3 = 1'b0; reqAddr3 = '0; reqWdata3 = '0;
        errors = 0; checks = 0; hCnt = 0; lastRd = 8'h00;
        for (int r = 0; r < 4; r++) begin
            expMem[r] = 8'h00;
            expMem3[r] = 8'h00;
        end
        $display("[TB] starting sram_array_ctrl bench");
        test_reset;
        test_reset_mid_pulse;
        test_round_trip;
        test_isolation;
        test_pulse_width;
        test_backpressure;
        test_back_to_back;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
